// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity mode constants
// Purpose: common types for the UART transmitter and receiver.
// Contents: uart_state_t frame states, PAR_* parity mode codes, parity_enabled().
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts baud ticks within one UART bit time
// Purpose: flags the tick that closes a bit after OSR baud ticks.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_baud_tick  1-clk pulse from the baud generator
//   i_clear      holds the count at zero (e.g. while idle)
//   o_bit_end    high on the clk where the OSR-th tick of a bit arrives
module uart_bit_timer #(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_baud_tick,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OSR - 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_last;

  assign w_last    = (r_tick_cnt == LAST_CNT);
  assign o_bit_end = i_baud_tick & ~i_clear & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (i_clear) begin
      r_tick_cnt <= '0;
    end else if (i_baud_tick) begin
      r_tick_cnt <= w_last ? '0 : r_tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with valid/ready front end
// Purpose: sends start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   baud_tick     baud generator pulse; OSR pulses per bit
//   tx_data       word to send, captured on accept
//   tx_valid      word available; accept = tx_valid & tx_ready
//   tx_ready      high in IDLE
//   parity_mode   00 none, 01 even, 10 odd, 11 none; captured on accept
//   stop2         two stop bits when 1; captured on accept
//   tx_busy       frame in progress
//   tx_done       1-clk pulse after the last stop bit
//   tx_line       registered serial output, idle high
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_line
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE_HOT0 = {{(DATA_W-1){1'b0}}, 1'b1};

  uart_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shadow, w_shadow_nxt;
  logic              r_par_en, w_par_en_nxt;
  logic              r_par_odd, w_par_odd_nxt;
  logic              r_stop2, w_stop2_nxt;
  logic              r_stop_second, w_stop_second_nxt;
  logic [IDX_W-1:0]  r_bit_idx, w_bit_idx_nxt;
  logic              r_tx_line, w_tx_line_nxt;
  logic              r_tx_done, w_tx_done_nxt;

  logic              w_bit_end;
  logic              w_idle;
  logic [IDX_W-1:0]  w_idx_inc;
  logic              w_next_data_bit;
  logic              w_parity_bit;

  assign w_idle = (r_state == ST_IDLE);

  // The timer is held cleared in IDLE so the start bit always lasts a full OSR.
  uart_bit_timer #(.OSR(OSR)) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_baud_tick (baud_tick),
    .i_clear     (w_idle),
    .o_bit_end   (w_bit_end)
  );

  assign w_idx_inc       = r_bit_idx + 1'b1;
  assign w_next_data_bit = |(r_shadow & (ONE_HOT0 << w_idx_inc));
  assign w_parity_bit    = r_par_odd ^ (^r_shadow);

  always_comb begin
    w_state_nxt       = r_state;
    w_shadow_nxt      = r_shadow;
    w_par_en_nxt      = r_par_en;
    w_par_odd_nxt     = r_par_odd;
    w_stop2_nxt       = r_stop2;
    w_stop_second_nxt = r_stop_second;
    w_bit_idx_nxt     = r_bit_idx;
    w_tx_line_nxt     = r_tx_line;
    w_tx_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_line_nxt = 1'b1;
        w_bit_idx_nxt = '0;
        if (tx_valid) begin
          w_shadow_nxt  = tx_data;
          w_par_en_nxt  = parity_enabled(parity_mode);
          w_par_odd_nxt = (parity_mode == PAR_ODD);
          w_stop2_nxt   = stop2;
          w_tx_line_nxt = 1'b0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
          w_tx_line_nxt = r_shadow[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_nxt = '0;
            if (r_par_en) begin
              w_state_nxt   = ST_PARITY;
              w_tx_line_nxt = w_parity_bit;
            end else begin
              w_state_nxt       = ST_STOP;
              w_stop_second_nxt = 1'b0;
              w_tx_line_nxt     = 1'b1;
            end
          end else begin
            w_bit_idx_nxt = w_idx_inc;
            w_tx_line_nxt = w_next_data_bit;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt       = ST_STOP;
          w_stop_second_nxt = 1'b0;
          w_tx_line_nxt     = 1'b1;
        end
      end
      ST_STOP: begin
        w_tx_line_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_second) begin
            w_stop_second_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_tx_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_tx_line_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shadow      <= '0;
      r_par_en      <= 1'b0;
      r_par_odd     <= 1'b0;
      r_stop2       <= 1'b0;
      r_stop_second <= 1'b0;
      r_bit_idx     <= '0;
      r_tx_line     <= 1'b1;
      r_tx_done     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shadow      <= w_shadow_nxt;
      r_par_en      <= w_par_en_nxt;
      r_par_odd     <= w_par_odd_nxt;
      r_stop2       <= w_stop2_nxt;
      r_stop_second <= w_stop_second_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_tx_line     <= w_tx_line_nxt;
      r_tx_done     <= w_tx_done_nxt;
    end
  end

  assign tx_ready = w_idle;
  assign tx_busy  = ~w_idle;
  assign tx_done  = r_tx_done;
  assign tx_line  = r_tx_line;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [1:0] parity_mode;
  logic       stop2;

  logic       v8, v5, v9;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [8:0] d9;
  logic       r8, b8, dn8, l8;
  logic       r5, b5, dn5, l5;
  logic       r9, b9, dn9, l9;

  int         sel;
  logic       m_ready, m_busy, m_done, m_line;

  int n_cmp;
  int n_err;

  uart_tx_cfg #(.DATA_W(8), .OSR(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(d8), .tx_valid(v8),
    .tx_ready(r8), .parity_mode(parity_mode), .stop2(stop2), .tx_busy(b8),
    .tx_done(dn8), .tx_line(l8));

  uart_tx_cfg #(.DATA_W(5), .OSR(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(d5), .tx_valid(v5),
    .tx_ready(r5), .parity_mode(parity_mode), .stop2(stop2), .tx_busy(b5),
    .tx_done(dn5), .tx_line(l5));

  uart_tx_cfg #(.DATA_W(9), .OSR(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(d9), .tx_valid(v9),
    .tx_ready(r9), .parity_mode(parity_mode), .stop2(stop2), .tx_busy(b9),
    .tx_done(dn9), .tx_line(l9));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    case (sel)
      1:       begin m_ready = r5; m_busy = b5; m_done = dn5; m_line = l5; end
      2:       begin m_ready = r9; m_busy = b9; m_done = dn9; m_line = l9; end
      default: begin m_ready = r8; m_busy = b8; m_done = dn8; m_line = l8; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int s, input logic [8:0] d, input logic [1:0] pm,
                             input logic s2, input bit hold, input string name);
    int n;
    sel = s;
    parity_mode = pm;
    stop2 = s2;
    case (s)
      1:       begin d5 = d[4:0]; v5 = 1'b1; end
      2:       begin d9 = d;      v9 = 1'b1; end
      default: begin d8 = d[7:0]; v8 = 1'b1; end
    endcase
    #1;
    n = 0;
    while (m_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 1000) begin
      n_err++;
      $display("FAIL %s_ready_wait: tx_ready=%b after %0d clks, required 1", name, m_ready, n);
    end
    step();
    if (!hold) begin
      v8 = 1'b0; v5 = 1'b0; v9 = 1'b0;
    end
    n_cmp++;
    if (m_line !== 1'b0 || m_busy !== 1'b1 || m_ready !== 1'b0 || m_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_accept: line=%b busy=%b ready=%b done=%b, required 0 1 0 0",
               name, m_line, m_busy, m_ready, m_done);
    end
  endtask

  // exp holds the frame as it appears on the line, first bit leftmost in nb bits.
  task automatic check_frame(input string name, input logic [15:0] exp, input int nb,
                             input int osr, input int maxgap);
    int  gap;
    bit  ok;
    logic want;
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      want = exp[nb-1-b];
      for (int t = 0; t < osr; t++) begin
        gap = (maxgap <= 1) ? 1 : int'($urandom_range(1, maxgap));
        for (int g = 0; g < gap; g++) begin
          if (m_line !== want || m_busy !== 1'b1 || m_ready !== 1'b0 || m_done !== 1'b0)
            ok = 1'b0;
          baud_tick = (g == gap - 1);
          step();
        end
      end
      baud_tick = 1'b0;
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s_bit%0d: line=%b busy=%b ready=%b done=%b, required line=%b busy=1 ready=0 done=0 for %0d ticks",
                 name, b, m_line, m_busy, m_ready, m_done, want, osr);
      end
    end
    n_cmp++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b1 || m_line !== 1'b1) begin
      n_err++;
      $display("FAIL %s_end: done=%b busy=%b ready=%b line=%b, required 1 0 1 1",
               name, m_done, m_busy, m_ready, m_line);
    end
  endtask

  task automatic check_done_clear(input string name);
    step();
    n_cmp++;
    if (m_done !== 1'b0 || m_line !== 1'b1 || m_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_pulse: done=%b line=%b busy=%b, required 0 1 0",
               name, m_done, m_line, m_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    sel = 0;
    n_cmp++;
    if (l8 !== 1'b1 || r8 !== 1'b1 || b8 !== 1'b0 || dn8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: line=%b ready=%b busy=%b done=%b, required 1 1 0 0", l8, r8, b8, dn8);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (l8 !== 1'b1 || r8 !== 1'b1 || b8 !== 1'b0 || dn8 !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: line=%b ready=%b busy=%b done=%b, required 1 1 0 0", l8, r8, b8, dn8);
    end
    start_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b0, "rst_mid");
    // 4 full bits (start, d0..d2) then partway into data bit 3, which is 0 for 0xA5
    for (int i = 0; i < 16 * 4 + 5; i++) begin
      baud_tick = 1'b1;
      step();
    end
    baud_tick = 1'b0;
    n_cmp++;
    if (l8 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_bit3: line=%b, required 0", l8);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (l8 !== 1'b1 || r8 !== 1'b1 || b8 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: line=%b ready=%b busy=%b, required 1 1 0", l8, r8, b8);
    end
    step();
    rst_n = 1'b1;
    step();
    start_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b0, "rst_clean");
    check_frame("rst_clean", 16'(10'b0_10100101_1), 10, 16, 1);
    check_done_clear("rst_clean");
  endtask

  task automatic test_basic();
    start_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b0, "a5");
    check_frame("a5", 16'(10'b0_10100101_1), 10, 16, 1);
    check_done_clear("a5");
  endtask

  task automatic test_parity();
    start_frame(0, 9'h007, 2'b01, 1'b0, 1'b0, "even07");
    check_frame("even07", 16'(11'b0_11100000_1_1), 11, 16, 1);
    check_done_clear("even07");
    start_frame(0, 9'h007, 2'b10, 1'b0, 1'b0, "odd07");
    check_frame("odd07", 16'(11'b0_11100000_0_1), 11, 16, 1);
    check_done_clear("odd07");
    start_frame(0, 9'h007, 2'b11, 1'b0, 1'b0, "rsv07");
    check_frame("rsv07", 16'(10'b0_11100000_1), 10, 16, 1);
    check_done_clear("rsv07");
  endtask

  task automatic test_stop2();
    start_frame(0, 9'h0FF, 2'b00, 1'b1, 1'b0, "stop2ff");
    check_frame("stop2ff", 16'(11'b0_11111111_11), 11, 16, 1);
    check_done_clear("stop2ff");
  endtask

  // Word stays pending while busy; data and config change mid-frame must not
  // disturb the frame in flight, and are picked up at the second accept.
  task automatic test_back_to_back(input int s, input logic [8:0] w0, input logic [1:0] pm0,
                                   input logic [15:0] e0, input int nb0,
                                   input logic [8:0] w1, input logic [1:0] pm1, input logic s2_1,
                                   input logic [15:0] e1, input int nb1,
                                   input int osr, input string name);
    start_frame(s, w0, pm0, 1'b0, 1'b1, name);
    case (s)
      1:       d5 = w1[4:0];
      2:       d9 = w1;
      default: d8 = w1[7:0];
    endcase
    parity_mode = pm1;
    stop2 = s2_1;
    check_frame({name, "_f0"}, e0, nb0, osr, 1);
    step();
    v8 = 1'b0; v5 = 1'b0; v9 = 1'b0;
    n_cmp++;
    if (m_line !== 1'b0 || m_busy !== 1'b1 || m_done !== 1'b0 || m_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_second_accept: line=%b busy=%b done=%b ready=%b, required 0 1 0 0",
               name, m_line, m_busy, m_done, m_ready);
    end
    check_frame({name, "_f1"}, e1, nb1, osr, 1);
    check_done_clear(name);
  endtask

  task automatic test_random_ticks();
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      step();
    end
    start_frame(0, 9'h03C, 2'b10, 1'b0, 1'b0, "rand3c");
    check_frame("rand3c", 16'(11'b0_00111100_1_1), 11, 16, 7);
    check_done_clear("rand3c");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel = 0;
    rst_n = 1'b0;
    baud_tick = 1'b0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    v8 = 1'b0; v5 = 1'b0; v9 = 1'b0;
    d8 = '0; d5 = '0; d9 = '0;

    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back(0, 9'h055, 2'b00, 16'(10'b0_10101010_1), 10,
                      9'h03C, 2'b01, 1'b0, 16'(11'b0_00111100_0_1), 11, 16, "b2b8");
    test_back_to_back(1, 9'h015, 2'b00, 16'(7'b0_10101_1), 7,
                      9'h00A, 2'b00, 1'b1, 16'(8'b0_01010_11), 8, 4, "b2b5");
    test_back_to_back(2, 9'h155, 2'b10, 16'(12'b0_101010101_0_1), 12,
                      9'h0C3, 2'b00, 1'b0, 16'(11'b0_110000110_1), 11, 4, "b2b9");
    test_random_ticks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
